sprite_lbuf_ctrl: RTL and testbench
===================================

# sprite_lbuf_ctrl

Parametrised double-buffered sprite line-buffer controller, successor to the 502-style sprite output stage.
- Owns two internal line-buffer banks. One is drawn by the sprite rasteriser with read-modify-write priority merging; the other is scanned out pixel-by-pixel and cleared behind the beam.
- Banks swap at every line start.
- Generalised in pixel width, pixels per RAM word, line length and priority mode.
- Sits between the sprite rasteriser and the video mixer.

## Interface
Parameters:
- PIXW, 4: colour index bits per pixel; value 0 is transparent.
- NPIX, 2: pixels packed per RAM word; power of two, 1..8.
- LINE_PIX, 256: pixels per line; multiple of NPIX.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CEN  in  1  pixel clock enable; all state holds when low.
- LINE_START  in  1  one-tick pulse (qualified by CEN) marking line start.
- PRIO_MODE  in  1  0 = first-drawn pixel wins; 1 = last-drawn non-transparent pixel wins.
- SPR_VALID  in  1  sprite pixel write request.
- SPR_READY  out  1  request accepted on a CEN tick with SPR_VALID && SPR_READY.
- SPR_X  in  $clog2(LINE_PIX)  target pixel X.
- SPR_PIX  in  PIXW  sprite colour index.
- BSEL  out  1  display bank index; the draw bank is ~BSEL.
- COL  out  PIXW+1  [PIXW-1:0] display pixel; [PIXW] = 1 when that pixel is 0.

## Operation
- Bank swap:
  - BSEL toggles on each LINE_START tick.
  - Display word counter and pixel phase reset to 0 on that tick.
- Display side:
  - Reads the display bank sequentially and emits one pixel per tick, LSB-first within each word (pixel k = bits [k*PIXW +: PIXW]).
  - After the last phase of word w, word w is written to all zeros.
  - After word LINE_PIX/NPIX-1 the counter stops: no further reads or clears, and COL = {1, 0} until the next LINE_START.
- Draw side, 2-stage pipeline:
  - Stage R reads word SPR_X/NPIX from the draw bank.
  - Stage W merges into lane SPR_X%NPIX and writes back.
  - Merge rule: SPR_PIX = 0 → no write. PRIO_MODE=0 → write only if the stored lane is 0. PRIO_MODE=1 → always write.
- Hazard: if stage R addresses the same bank and word that stage W is writing, merge uses the stage-W result (forwarding), not stale RAM data.
- Each in-flight op latches its bank index at acceptance. A stage-W op pending at LINE_START completes into its original bank.
- SPR_READY = 0 on the LINE_START tick; 1 otherwise after reset.
- SPR_X >= LINE_PIX is accepted and discarded.
- Reset values: BSEL=0, COL={1, 0}, counters 0, pipeline empty, SPR_READY=1.
- RAM contents are not reset; the first displayed line after reset is undefined.

## Timing
- RAM reads are synchronous, 1 tick.
- Display latency: the LINE_START tick is tick 0. Pixel n appears on COL at CEN tick n+2, registered.
- Clear of word w is written on the tick its last pixel is registered to COL.
- Draw:
  - Accepted at tick t.
  - Written to RAM at tick t+1.
  - Visible on display no earlier than the line after the next LINE_START.
- Throughput: one draw per tick, including back-to-back writes to the same word.
- LINE_START and SPR_VALID together: the request is not accepted and must be held.
- CEN low: no state change; outputs hold.
- RST_N asserted mid-line: immediate return to reset values; pending draw op dropped.

## Structure
- Package sprite_lbuf_pkg holds:
  - Derived localparams WORDS = LINE_PIX/NPIX, AW = $clog2(WORDS), LW = $clog2(NPIX).
  - typedef of the draw-op struct {bank, word addr, lane, pix, valid}.
  - Merge function lane_merge(word, lane, pix, mode).
- Sub-module sprite_lbuf_bank: one simple dual-port RAM (1 sync read, 1 write), WORDS × NPIX*PIXW, instantiated twice.
- Bank port muxing, display counter and draw pipeline live in the top.

## Test plan
- Reset, no draws, defaults: LINE_START then 300 ticks → COL = 5'h10 every tick; BSEL toggles on each LINE_START.
- Basic draw: draw X=5 pix=3 on line L, LINE_START → COL = 5'h03 exactly at tick 7, 5'h10 elsewhere. The following line shows 5'h10 at X=5 (cleared).
- Priority: draw X=9 pix=2 then X=9 pix=7 back-to-back (forwarding).
  - PRIO_MODE=0 → displays 2.
  - PRIO_MODE=1 → displays 7.
  - Repeat for X=8/X=9 in the same word: both lanes are preserved.
- Transparent and out-of-range: SPR_PIX=0 over existing 5, and SPR_X ≥ LINE_PIX (LINE_PIX=240 build) → stored 5 unchanged, no corruption of word 0.
- Line boundary: SPR_VALID held across LINE_START.
  - SPR_READY=0 on that tick.
  - An op accepted the tick before lands in the old draw bank and displays next line.
- Robustness:
  - Random CEN gaps (~50%) → identical COL sequence to CEN=1 reference model.
  - RST_N pulse mid-line → COL=5'h10, BSEL=0 immediately.
  - NPIX=1, 4, 8 builds pass the above.

Source files
------------

// File: rtl/sprite_lbuf_pkg.sv
// Shared types and helpers for the double-buffered sprite line buffer.
// Op fields are sized for the largest supported build; the top truncates to its own widths.
package sprite_lbuf_pkg;

   localparam int PIXW_DEF     = 4;
   localparam int NPIX_DEF     = 2;
   localparam int LINE_PIX_DEF = 256;

   localparam int WORDS = LINE_PIX_DEF / NPIX_DEF;
   localparam int AW    = $clog2(WORDS);
   localparam int LW    = $clog2(NPIX_DEF);

   localparam int MAX_AW   = 12;
   localparam int MAX_LW   = 3;
   localparam int MAX_PIXW = 8;
   localparam int MAX_WW   = 64;

   typedef struct packed {
      logic                bank;
      logic [MAX_AW-1:0]   addr;
      logic [MAX_LW-1:0]   lane;
      logic [MAX_PIXW-1:0] pix;
      logic                valid;
   } draw_op_t;

   // Returns the word unchanged when the pixel loses priority or is transparent.
   function automatic logic [MAX_WW-1:0] lane_merge(
      input logic [MAX_WW-1:0]   word,
      input logic [MAX_LW-1:0]   lane,
      input logic [MAX_PIXW-1:0] pix,
      input logic                mode,
      input int                  pixw
   );
      logic [MAX_WW-1:0] mask;
      logic [MAX_WW-1:0] ins;
      int                sh;
      sh   = int'(lane) * pixw;
      mask = ((MAX_WW'(1) << pixw) - MAX_WW'(1)) << sh;
      ins  = (MAX_WW'(pix) << sh) & mask;
      if (pix == '0)
         return word;
      if (!mode && ((word & mask) != '0))
         return word;
      return (word & ~mask) | ins;
   endfunction

endpackage

// File: rtl/sprite_lbuf_ctrl_if.sv
// Rasteriser-to-line-buffer pixel write handshake.
interface sprite_lbuf_ctrl_if
   import sprite_lbuf_pkg::*;
#(
    parameter int PIXW = PIXW_DEF,
    parameter int XW   = $clog2(LINE_PIX_DEF)
);
    logic            spr_valid;
    logic            spr_ready;
    logic [XW-1:0]   spr_x;
    logic [PIXW-1:0] spr_pix;

    modport master (output spr_valid, output spr_x, output spr_pix, input spr_ready);
    modport slave  (input spr_valid, input spr_x, input spr_pix, output spr_ready);
endinterface

// File: rtl/sprite_lbuf_bank.sv
// One line-buffer bank: simple dual-port RAM, one synchronous read and one write port.
module sprite_lbuf_bank
   import sprite_lbuf_pkg::*;
#(
    parameter int N_WORDS = 128,
    parameter int WW      = 8,
    parameter int A_W     = $clog2(N_WORDS)
) (
    input  logic           clk_i,
    input  logic           we_i,
    input  logic [A_W-1:0] waddr_i,
    input  logic [WW-1:0]  wdata_i,
    input  logic           re_i,
    input  logic [A_W-1:0] raddr_i,
    output logic [WW-1:0]  rdata_o
);
    logic [WW-1:0] mem_q [N_WORDS];

    // Read-during-write returns the old word; the draw pipeline forwards around it.
    always_ff @(posedge clk_i) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
        if (re_i)
            rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/sprite_lbuf_ctrl.sv
// Double-buffered sprite line buffer: rasteriser merges into the draw bank while the
// display bank is scanned out one pixel per tick and cleared behind the beam.
module sprite_lbuf_ctrl
   import sprite_lbuf_pkg::*;
#(
    parameter int PIXW     = PIXW_DEF,
    parameter int NPIX     = NPIX_DEF,
    parameter int LINE_PIX = LINE_PIX_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cen_i,
    input  logic              line_start_i,
    input  logic              prio_mode_i,
    sprite_lbuf_ctrl_if.slave spr,
    output logic              bsel_o,
    output logic [PIXW:0]     col_o
);
    localparam int N_WORDS = LINE_PIX / NPIX;
    localparam int A_W     = $clog2(N_WORDS);
    localparam int LOGN    = $clog2(NPIX);
    localparam int L_W     = (NPIX > 1) ? LOGN : 1;
    localparam int WW      = NPIX * PIXW;
    localparam int XW      = $clog2(LINE_PIX);
    localparam logic [PIXW:0] IDLE = {1'b1, {PIXW{1'b0}}};

    logic ls;
    logic accept;
    logic x_ok;

    logic           bsel_q, bsel_d;
    logic [A_W-1:0] dcnt_q, dcnt_d;
    logic [L_W-1:0] dph_q, dph_d;
    logic           run_q, run_d;
    logic           disp_rd;

    logic           dv_q, dv_d;
    logic [A_W-1:0] daddr_q;
    logic [L_W-1:0] dlane_q;
    logic           dbank_q;
    logic [PIXW:0]  col_q, col_d;
    logic [WW-1:0]  disp_word;
    logic [PIXW-1:0] disp_pix;
    logic           clr_we;

    draw_op_t       op_q, op_d, op_in;
    logic           fwd_q, fwd_d;
    logic [WW-1:0]  fwd_word_q;
    logic [WW-1:0]  base_word;
    logic [WW-1:0]  merged;
    logic           draw_we;
    logic [A_W-1:0] draw_raddr;

    logic [WW-1:0]  rdata [2];

    assign ls            = cen_i && line_start_i;
    assign spr.spr_ready = !ls;
    assign accept        = cen_i && spr.spr_valid && !line_start_i;
    assign x_ok          = {1'b0, spr.spr_x} < (XW+1)'(LINE_PIX);
    assign draw_raddr    = A_W'(spr.spr_x >> LOGN);

    // Display word counter and pixel phase.
    always_comb begin
        bsel_d  = bsel_q ^ ls;
        dcnt_d  = dcnt_q;
        dph_d   = dph_q;
        run_d   = run_q;
        disp_rd = run_q && (dph_q == '0);
        if (ls) begin
            run_d  = 1'b1;
            dcnt_d = '0;
            dph_d  = '0;
        end else if (run_q) begin
            if (dph_q == L_W'(NPIX-1)) begin
                dph_d = '0;
                if (dcnt_q == A_W'(N_WORDS-1))
                    run_d = 1'b0;
                else
                    dcnt_d = dcnt_q + 1'b1;
            end else begin
                dph_d = dph_q + 1'b1;
            end
        end
    end

    always_comb begin
        dv_d      = ls ? 1'b0 : run_q;
        disp_word = dbank_q ? rdata[1] : rdata[0];
        disp_pix  = disp_word[dlane_q*PIXW +: PIXW];
        col_d     = IDLE;
        if (dv_q)
            col_d = {(disp_pix == '0), disp_pix};
        clr_we    = cen_i && dv_q && (dlane_q == L_W'(NPIX-1));
    end

    // Draw pipeline: stage R is the accept tick, stage W merges and writes back.
    always_comb begin
        op_in       = '0;
        op_in.bank  = ~bsel_q;
        op_in.addr  = MAX_AW'(spr.spr_x >> LOGN);
        op_in.lane  = MAX_LW'(spr.spr_x & XW'(NPIX-1));
        op_in.pix   = MAX_PIXW'(spr.spr_pix);
        op_in.valid = x_ok;

        base_word = fwd_q ? fwd_word_q : (op_q.bank ? rdata[1] : rdata[0]);
        merged    = WW'(lane_merge(MAX_WW'(base_word), op_q.lane, op_q.pix, prio_mode_i, PIXW));
        draw_we   = cen_i && op_q.valid;

        op_d  = accept ? op_in : '0;
        fwd_d = accept && op_in.valid && op_q.valid &&
                (op_q.bank == op_in.bank) && (op_q.addr == op_in.addr);
    end

    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
        logic           is_disp;
        logic           w_draw;
        logic           we;
        logic [A_W-1:0] waddr;
        logic [WW-1:0]  wdata;
        logic           re;
        logic [A_W-1:0] raddr;

        // A pending draw and a clear never share a bank; draw wins defensively.
        always_comb begin
            is_disp = (bsel_q == 1'(gb));
            w_draw  = draw_we && (op_q.bank == 1'(gb));
            we      = w_draw || (clr_we && (dbank_q == 1'(gb)));
            waddr   = w_draw ? A_W'(op_q.addr) : daddr_q;
            wdata   = w_draw ? merged : '0;
            re      = cen_i && (is_disp ? disp_rd : (accept && x_ok));
            raddr   = is_disp ? dcnt_q : draw_raddr;
        end

        sprite_lbuf_bank #(
            .N_WORDS (N_WORDS),
            .WW      (WW),
            .A_W     (A_W)
        ) u_bank (
            .clk_i   (clk_i),
            .we_i    (we),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .re_i    (re),
            .raddr_i (raddr),
            .rdata_o (rdata[gb])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bsel_q     <= 1'b0;
            dcnt_q     <= '0;
            dph_q      <= '0;
            run_q      <= 1'b0;
            dv_q       <= 1'b0;
            daddr_q    <= '0;
            dlane_q    <= '0;
            dbank_q    <= 1'b0;
            col_q      <= IDLE;
            op_q       <= '0;
            fwd_q      <= 1'b0;
            fwd_word_q <= '0;
        end else if (cen_i) begin
            bsel_q     <= bsel_d;
            dcnt_q     <= dcnt_d;
            dph_q      <= dph_d;
            run_q      <= run_d;
            dv_q       <= dv_d;
            daddr_q    <= dcnt_q;
            dlane_q    <= dph_q;
            dbank_q    <= bsel_q;
            col_q      <= col_d;
            op_q       <= op_d;
            fwd_q      <= fwd_d;
            fwd_word_q <= merged;
        end
    end

    assign bsel_o = bsel_q;
    assign col_o  = col_q;
endmodule

// File: tb/tb_sprite_lbuf_ctrl.sv
// Bench for sprite_lbuf_ctrl: pixel-level reference of both banks, scripted and random draws.
module tb_sprite_lbuf_ctrl;
    localparam int PIXW     = 4;
    localparam int NPIX     = 2;
    localparam int LINE_PIX = 240;
    localparam int XW       = $clog2(LINE_PIX);
    localparam int LT       = LINE_PIX + 16;
    localparam logic [PIXW:0] IDLE = {1'b1, {PIXW{1'b0}}};

    logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0, line_start = 1'b0, prio = 1'b0;
    logic bsel;
    logic [PIXW:0] col;

    sprite_lbuf_ctrl_if #(.PIXW(PIXW), .XW(XW)) sif ();

    sprite_lbuf_ctrl #(.PIXW(PIXW), .NPIX(NPIX), .LINE_PIX(LINE_PIX)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cen_i        (cen),
        .line_start_i (line_start),
        .prio_mode_i  (prio),
        .spr          (sif),
        .bsel_o       (bsel),
        .col_o        (col)
    );

    always #5 clk = ~clk;

    typedef struct { int ln; int t; int x; int pix; } draw_t;
    draw_t drq[$];

    int n_cmp = 0, n_fail = 0;
    logic [PIXW-1:0] mbank [2][LINE_PIX];
    int mbsel = 0, mk = 100000, ln = 0;
    bit gaps = 0;
    logic [PIXW:0] last_exp = IDLE;
    logic [PIXW:0] cap [LT];

    function automatic logic [PIXW:0] pe(input int v);
        return (PIXW+1)'(v);
    endfunction

    task automatic zero_model();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < LINE_PIX; i++) mbank[b][i] = '0;
    endtask

    // One CEN tick (optionally preceded by CEN-low gaps); advances the pixel-level model.
    task automatic step(input bit ls, input bit v, input int x, input int pix,
                        output bit rdy_bad, output bit hold_bad);
        bit acc;
        hold_bad = 0;
        line_start    = ls;
        sif.spr_valid = v;
        sif.spr_x     = XW'(x);
        sif.spr_pix   = PIXW'(pix);
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                cen = 1'b0;
                @(posedge clk); #1;
                if (col !== last_exp || bsel !== mbsel[0]) hold_bad = 1;
            end
        end
        cen = 1'b1;
        #1;
        rdy_bad = (sif.spr_ready !== !ls);
        acc = v && !ls;
        @(posedge clk); #1;
        if (acc && x < LINE_PIX && pix != 0 && (prio || mbank[1-mbsel][x] == '0))
            mbank[1-mbsel][x] = PIXW'(pix);
        if (ls) begin
            mbsel = 1 - mbsel;
            mk = 0;
        end else if (mk < 100000) begin
            mk++;
        end
        if (mk >= 2 && mk - 2 < LINE_PIX) begin
            last_exp = (mbank[mbsel][mk-2] == '0) ? IDLE : {1'b0, mbank[mbsel][mk-2]};
            mbank[mbsel][mk-2] = '0;
        end else begin
            last_exp = IDLE;
        end
    endtask

    task automatic run_line(input bit chk);
        bit rb, hb, v;
        int x, p;
        for (int t = 0; t < LT; t++) begin
            v = 0; x = 0; p = 0;
            foreach (drq[i])
                if (drq[i].ln == ln && drq[i].t == t) begin
                    v = 1; x = drq[i].x; p = drq[i].pix;
                end
            step(t == 0, v, x, p, rb, hb);
            cap[t] = col;
            if (chk) begin
                n_cmp++;
                if (col !== last_exp) begin
                    n_fail++;
                    $display("FAIL col line %0d tick %0d: got %h want %h", ln, t, col, last_exp);
                end
                n_cmp++;
                if (bsel !== mbsel[0]) begin
                    n_fail++;
                    $display("FAIL bsel line %0d tick %0d: got %b want %b", ln, t, bsel, mbsel[0]);
                end
                n_cmp++;
                if (rb) begin
                    n_fail++;
                    $display("FAIL ready line %0d tick %0d: want %b", ln, t, !(t == 0));
                end
                if (gaps) begin
                    n_cmp++;
                    if (hb) begin
                        n_fail++;
                        $display("FAIL cen_hold line %0d tick %0d: outputs moved, want col %h", ln, t, last_exp);
                    end
                end
            end
        end
        ln++;
    endtask

    task automatic warmup();
        run_line(0);
        run_line(0);
        zero_model();
    endtask

    task automatic add_random(input int l, input int density);
        for (int t = 1; t < LT - 1; t++)
            if ($urandom_range(99, 0) < density)
                drq.push_back('{l, t, int'($urandom_range((1 << XW) - 1, 0)),
                                int'($urandom_range((1 << PIXW) - 1, 0))});
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (col !== IDLE) begin n_fail++; $display("FAIL reset_col: got %h want %h", col, IDLE); end
        n_cmp++;
        if (bsel !== 1'b0) begin n_fail++; $display("FAIL reset_bsel: got %b want 0", bsel); end
        n_cmp++;
        if (sif.spr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", sif.spr_ready); end
    endtask

    task automatic test_idle();
        run_line(1);
        run_line(1);
    endtask

    task automatic test_basic();
        prio = 1'b0;
        drq.push_back('{ln, 10, 5, 3});
        run_line(1);
        run_line(1);
        n_cmp++;
        if (cap[7] !== pe(3)) begin n_fail++; $display("FAIL basic_x5: got %h want %h", cap[7], pe(3)); end
        run_line(1);
        n_cmp++;
        if (cap[7] !== IDLE) begin n_fail++; $display("FAIL basic_cleared: got %h want %h", cap[7], IDLE); end
    endtask

    task automatic test_priority();
        for (int m = 0; m < 2; m++) begin
            prio = m[0];
            drq.push_back('{ln, 20, 9, 2});
            drq.push_back('{ln, 21, 9, 7});
            drq.push_back('{ln, 22, 8, 4});
            run_line(1);
            run_line(1);
            n_cmp++;
            if (cap[11] !== pe(m ? 7 : 2)) begin
                n_fail++; $display("FAIL prio%0d_x9: got %h want %h", m, cap[11], pe(m ? 7 : 2));
            end
            n_cmp++;
            if (cap[10] !== pe(4)) begin
                n_fail++; $display("FAIL prio%0d_x8: got %h want %h", m, cap[10], pe(4));
            end
        end
    endtask

    task automatic test_transparent_oob();
        prio = 1'b1;
        drq.push_back('{ln, 10, 5, 5});
        drq.push_back('{ln, 11, 5, 0});
        drq.push_back('{ln, 12, 1, 3});
        if (LINE_PIX < (1 << XW)) begin
            drq.push_back('{ln, 13, LINE_PIX, 9});
            drq.push_back('{ln, 14, (1 << XW) - 1, 9});
        end
        run_line(1);
        run_line(1);
        n_cmp++;
        if (cap[7] !== pe(5)) begin n_fail++; $display("FAIL transparent: got %h want %h", cap[7], pe(5)); end
        n_cmp++;
        if (cap[3] !== pe(3)) begin n_fail++; $display("FAIL oob_word0_x1: got %h want %h", cap[3], pe(3)); end
        n_cmp++;
        if (cap[2] !== IDLE) begin n_fail++; $display("FAIL oob_word0_x0: got %h want %h", cap[2], IDLE); end
    endtask

    task automatic test_line_boundary();
        prio = 1'b0;
        drq.push_back('{ln, LT - 1, 30, 10});
        drq.push_back('{ln + 1, 0, 31, 11});
        drq.push_back('{ln + 1, 1, 31, 11});
        run_line(1);
        run_line(1);
        n_cmp++;
        if (cap[32] !== pe(10)) begin n_fail++; $display("FAIL boundary_prev: got %h want %h", cap[32], pe(10)); end
        n_cmp++;
        if (cap[33] !== IDLE) begin n_fail++; $display("FAIL boundary_held_early: got %h want %h", cap[33], IDLE); end
        run_line(1);
        n_cmp++;
        if (cap[33] !== pe(11)) begin n_fail++; $display("FAIL boundary_held: got %h want %h", cap[33], pe(11)); end
    endtask

    task automatic test_random();
        for (int l = 0; l < 5; l++) begin
            prio = 1'($urandom_range(1, 0));
            add_random(ln, 50);
            run_line(1);
        end
        run_line(1);
    endtask

    task automatic test_cen_gaps();
        gaps = 1;
        for (int l = 0; l < 3; l++) begin
            prio = 1'($urandom_range(1, 0));
            add_random(ln, 40);
            run_line(1);
        end
        run_line(1);
        gaps = 0;
    endtask

    task automatic test_reset_midline();
        bit rb, hb;
        step(1, 0, 0, 0, rb, hb);
        if (mbsel == 0) step(1, 0, 0, 0, rb, hb);
        for (int t = 0; t < 49; t++) step(0, (t == 48), 40, 9, rb, hb);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (col !== IDLE) begin n_fail++; $display("FAIL midreset_col: got %h want %h", col, IDLE); end
        n_cmp++;
        if (bsel !== 1'b0) begin n_fail++; $display("FAIL midreset_bsel: got %b want 0", bsel); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mbsel = 0; mk = 100000; last_exp = IDLE;
        warmup();
        prio = 1'b0;
        add_random(ln, 30);
        run_line(1);
        run_line(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.spr_valid = 1'b0;
        sif.spr_x     = '0;
        sif.spr_pix   = '0;
        zero_model();
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        warmup();
        test_idle();
        test_basic();
        test_priority();
        test_transparent_oob();
        test_line_boundary();
        test_random();
        test_cen_gaps();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
